// File: rtl/serial_logic_unit_pkg.sv
// Shared op codes and FSM state encoding for the serial logic unit.
package serial_logic_unit_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_NOT    = 3'd4;
    localparam logic [2:0] OP_BUF    = 3'd5;
    localparam logic [2:0] OP_MUX    = 3'd6;
    localparam logic [2:0] OP_TOGGLE = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Pin-level bus of the serial logic unit: serial load, start/op and result flags.
interface serial_logic_unit_if #(
    parameter int unsigned WIDTH = 4
);
    logic             shift_en;
    logic             shift_in;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] result;
    logic             valid;
    logic             ready;
    logic             zero;
    logic             err;

    modport master (
        output shift_en, shift_in, start, op,
        input  result, valid, ready, zero, err
    );

    modport slave (
        input  shift_en, shift_in, start, op,
        output result, valid, ready, zero, err
    );
endinterface

// File: rtl/slu_op_unit.sv
// Combinational function unit: bitwise op over A/B, with the old result used by MUX and TOGGLE.
module slu_op_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] y
);

    // Decode op into the selected bitwise function
    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOT:    y = ~a;
            OP_BUF:    y = a;
            OP_MUX:    y = (prev & b) | (~prev & a);  // old result selects B per bit
            OP_TOGGLE: y = prev ^ a;                  // result bank acts as T flip-flops
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Programmable logic unit with bit-serial operand load and registered, flagged result.
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic           clk,
    input logic           reset,
    serial_logic_unit_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(2 * WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 * WIDTH);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   sr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     result_q;
    logic                 valid_q;
    logic                 err_q;

    logic                 ready;
    logic                 do_accept;
    logic                 do_reject;
    logic                 do_shift;
    logic                 do_exec;
    logic [WIDTH-1:0]     op_y;

    assign ready = (cnt_q == CNT_FULL);

    // Next state and per-cycle control; start takes priority over shift in IDLE
    always_comb begin
        state_d   = state_q;
        do_accept = 1'b0;
        do_reject = 1'b0;
        do_shift  = 1'b0;
        do_exec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (ready) begin
                        do_accept = 1'b1;
                        state_d   = ST_EXEC;
                    end else begin
                        do_reject = 1'b1;
                    end
                end else if (bus.shift_en) begin
                    do_shift = 1'b1;
                end
            end
            ST_EXEC: begin
                do_exec = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift register and saturating bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (do_shift) begin
            sr_q <= {sr_q[2*WIDTH-2:0], bus.shift_in};
            if (cnt_q != CNT_FULL) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    slu_op_unit #(
        .WIDTH (WIDTH)
    ) u_op_unit (
        .op   (op_q),
        .a    (sr_q[2*WIDTH-1:WIDTH]),
        .b    (sr_q[WIDTH-1:0]),
        .prev (result_q),
        .y    (op_y)
    );

    // Op latch, result register, valid pulse and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= do_exec;
            if (do_accept) begin
                op_q  <= bus.op;
                err_q <= 1'b0;
            end
            if (do_reject) begin
                err_q <= 1'b1;
            end
            if (do_exec) begin
                result_q <= op_y;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
    assign bus.ready  = ready;
    assign bus.zero   = (result_q == '0);
    assign bus.err    = err_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed plus randomized bench for serial_logic_unit against a cycle-level behavioural model.
module tb_serial_logic_unit;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    serial_logic_unit_if #(.WIDTH(W)) bus ();

    serial_logic_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: operand bits as a 2W-bit number, pending-exec flag, result and flags
    int unsigned      m_sr      = 0;
    int unsigned      m_nbits   = 0;
    bit               m_pending = 0;
    logic [2:0]       m_op      = 0;
    logic [W-1:0]     m_res     = 0;
    bit               m_valid   = 0;
    bit               m_err     = 0;

    function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] r);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < W; i++) begin
            case (o)
                3'd0: y[i] = a[i] & b[i];
                3'd1: y[i] = a[i] | b[i];
                3'd2: y[i] = a[i] != b[i];
                3'd3: y[i] = !(a[i] & b[i]);
                3'd4: y[i] = !a[i];
                3'd5: y[i] = a[i];
                3'd6: y[i] = r[i] ? b[i] : a[i];
                default: y[i] = r[i] != a[i];
            endcase
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: apply inputs, advance model, compare every output
    task automatic cyc(input logic rst, input logic en, input logic si, input logic st,
                       input logic [2:0] o);
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset        = rst;
        bus.shift_en = en;
        bus.shift_in = si;
        bus.start    = st;
        bus.op       = o;
        @(posedge clk);
        #1;
        a = W'(m_sr / (1 << W));
        b = W'(m_sr % (1 << W));
        if (rst) begin
            m_sr = 0; m_nbits = 0; m_pending = 0; m_op = 0;
            m_res = 0; m_valid = 0; m_err = 0;
        end else if (m_pending) begin
            m_res     = ref_f(m_op, a, b, m_res);
            m_valid   = 1;
            m_pending = 0;
        end else begin
            m_valid = 0;
            if (st) begin
                if (m_nbits == 2 * W) begin
                    m_op = o; m_err = 0; m_pending = 1;
                end else begin
                    m_err = 1;
                end
            end else if (en) begin
                m_sr = (m_sr * 2 + int'(si)) % (1 << (2 * W));
                if (m_nbits < 2 * W) m_nbits++;
            end
        end
        chk("result", 32'(bus.result), 32'(m_res));
        chk("valid",  32'(bus.valid),  32'(m_valid));
        chk("ready",  32'(bus.ready),  32'(m_nbits == 2 * W));
        chk("zero",   32'(bus.zero),   32'(m_res == 0));
        chk("err",    32'(bus.err),    32'(m_err));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic shift_bits(input logic [7:0] pat, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) cyc(1'b0, 1'b1, pat[i], 1'b0, 3'd0);
    endtask

    // Start an op, then check the registered result and valid pulse two edges later
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] exp);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, o);
        chk("valid_gap", 32'(bus.valid), 32'd0);
        idle();
        chk("op_result", 32'(bus.result), 32'(exp));
        chk("op_valid",  32'(bus.valid),  32'd1);
    endtask

    logic [7:0] pat;

    initial begin
        pat = 8'b1010_0110;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_valid",  32'(bus.valid),  32'd0);
        chk("rst_ready",  32'(bus.ready),  32'd0);
        chk("rst_zero",   32'(bus.zero),   32'd1);
        chk("rst_err",    32'(bus.err),    32'd0);

        // Load A=0xA, B=0x6 and run the basic ops
        shift_bits(pat, 7, 0);
        chk("ready_after_load", 32'(bus.ready), 32'd1);
        run_op(3'd0, 4'h2);
        chk("and_zero", 32'(bus.zero), 32'd0);
        run_op(3'd2, 4'hC);
        run_op(3'd3, 4'hD);
        run_op(3'd4, 4'h5);
        run_op(3'd5, 4'hA);
        idle();
        chk("valid_one_cycle", 32'(bus.valid), 32'd0);

        // Start before ready raises err and produces nothing
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        shift_bits(pat, 7, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        chk("early_err",   32'(bus.err),    32'd1);
        idle();
        chk("early_valid", 32'(bus.valid),  32'd0);
        chk("early_res",   32'(bus.result), 32'd0);
        chk("err_sticky",  32'(bus.err),    32'd1);
        shift_bits(pat, 2, 0);
        run_op(3'd1, 4'hE);
        chk("err_cleared", 32'(bus.err), 32'd0);

        // TOGGLE and MUX chain from a zero result
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        shift_bits(pat, 7, 0);
        run_op(3'd7, 4'hA);
        run_op(3'd7, 4'h0);
        chk("toggle_zero", 32'(bus.zero), 32'd1);
        run_op(3'd7, 4'hA);
        run_op(3'd6, 4'h2);

        // Start together with shift_en: shift must be dropped
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
        idle();
        chk("start_shift_buf", 32'(bus.result), 32'hA);
        run_op(3'd2, 4'hC);

        // Reset during EXEC suppresses the valid pulse
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("rexec_valid", 32'(bus.valid),  32'd0);
        chk("rexec_res",   32'(bus.result), 32'd0);
        chk("rexec_ready", 32'(bus.ready),  32'd0);
        chk("rexec_zero",  32'(bus.zero),   32'd1);
        idle();
        chk("rexec_novalid", 32'(bus.valid), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom),
                ($urandom_range(0, 3) == 0), 3'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
